fib_gray_descrambler: RTL and testbench



---
 rtl/fib_gray_descrambler_if.sv | 23 ++
 rtl/fib_gray_descrambler.sv | 86 ++++++++
 tb/tb_fib_gray_descrambler.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/fib_gray_descrambler_if.sv
// Valid/ready stream bundle between the scrambler link and the payload consumer.
// The master side drives words in and accepts results; the slave side is the descrambler.
interface fib_gray_descrambler_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_resync;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, in_resync, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_resync, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/fib_gray_descrambler.sv
// Strips a Fibonacci keystream from each scrambled word, then converts the LSB-anchored
// Gray result back to binary through a two-stage pipeline with full backpressure.
module fib_gray_descrambler #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] SEED0 = 16'h0000,
    parameter logic [WIDTH-1:0] SEED1 = 16'h0001
) (
    input  logic                          clk,
    input  logic                          rst_n,
    fib_gray_descrambler_if.slave         bus,
    output logic [15:0]                   word_count
);

    logic [WIDTH-1:0] key_a;
    logic [WIDTH-1:0] key_b;
    logic             s1_valid;
    logic [WIDTH-1:0] s1_data;
    logic             s2_valid;
    logic [WIDTH-1:0] s2_data;

    logic s2_load;
    logic s1_move;
    logic accept;

    function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[0] = g[0];
        for (int i = 1; i < WIDTH; i++) begin
            b[i] = g[i] ^ b[i-1];
        end
        return b;
    endfunction

    // Ready chains back combinationally from out_ready; there is no skid buffer.
    assign s2_load = !s2_valid || bus.out_ready;
    assign s1_move = s1_valid && s2_load;
    assign bus.in_ready = !s1_valid || s1_move;
    assign accept = bus.in_valid && bus.in_ready;

    assign bus.out_valid = s2_valid;
    assign bus.out_data  = s2_data;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_a      <= SEED0;
            key_b      <= SEED1;
            word_count <= '0;
        end else begin
            if (bus.in_resync) begin
                key_a <= SEED0;
                key_b <= SEED1;
            end else if (accept) begin
                key_a <= key_b;
                key_b <= key_a + key_b;
            end
            if (accept) begin
                word_count <= word_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_data  <= bus.in_data ^ key_a;
            end else if (s1_move) begin
                s1_valid <= 1'b0;
            end

            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= gray_to_bin(s1_data);
                end
            end
        end
    end

endmodule

// File: tb/tb_fib_gray_descrambler.sv
// Directed bench for the Fibonacci/Gray descrambler: round trip, backpressure,
// keystream wrap, resync collision and mid-stream reset.
module tb_fib_gray_descrambler;

    logic        clk;
    logic        rst_n;
    logic [15:0] word_count;

    fib_gray_descrambler_if #(.WIDTH(16)) bus ();

    fib_gray_descrambler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] outs [0:31];
    int          n_out;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_resync = 1'b0;
        bus.out_ready = 1'b1;
        step();
        step();
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_out_data", {16'd0, bus.out_data}, 32'd0);
        check("rst_word_count", {16'd0, word_count}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    endtask

    task automatic send_word(input logic [15:0] data, input logic resync);
        logic ok;
        ok            = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = data;
        bus.in_resync = resync;
        for (int k = 0; k < 20; k++) begin
            if (bus.in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        check("accept_in_time", {31'd0, ok}, 32'd1);
        step();
        bus.in_valid  = 1'b0;
        bus.in_resync = 1'b0;
    endtask

    task automatic collect(input logic [15:0] exp, input string tag);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (bus.out_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        check({tag, "_arrive"}, {31'd0, ok}, 32'd1);
        check(tag, {16'd0, bus.out_data}, {16'd0, exp});
        step();
    endtask

    // Streams n zero words back-to-back with out_ready high; pulses resync on word rs_idx.
    task automatic run_stream(input int n, input int rs_idx);
        n_out         = 0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < n + 4; c++) begin
            if (c < n) begin
                bus.in_valid  = 1'b1;
                bus.in_data   = 16'h0000;
                bus.in_resync = (c == rs_idx);
            end else begin
                bus.in_valid  = 1'b0;
                bus.in_resync = 1'b0;
            end
            step();
            if (bus.out_valid === 1'b1 && n_out < 32) begin
                outs[n_out] = bus.out_data;
                n_out++;
            end
        end
        check("stream_count", n_out, n);
    endtask

    initial begin
        // Basic round trip: keys 0,1,1,2 turn every word into Gray 0x0001 -> 0xFFFF.
        do_reset();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'h0001;
        step();
        check("rt_latency_low", {31'd0, bus.out_valid}, 32'd0);
        bus.in_data = 16'h0000;
        step();
        check("rt_valid_0", {31'd0, bus.out_valid}, 32'd1);
        check("rt_data_0", {16'd0, bus.out_data}, 32'hFFFF);
        bus.in_data = 16'h0000;
        step();
        check("rt_data_1", {16'd0, bus.out_data}, 32'hFFFF);
        bus.in_data = 16'h0003;
        step();
        check("rt_data_2", {16'd0, bus.out_data}, 32'hFFFF);
        bus.in_valid = 1'b0;
        step();
        check("rt_data_3", {16'd0, bus.out_data}, 32'hFFFF);
        check("rt_word_count", {16'd0, word_count}, 32'd4);
        step();
        check("rt_drained", {31'd0, bus.out_valid}, 32'd0);

        // Single word.
        do_reset();
        send_word(16'h0003, 1'b0);
        collect(16'h0001, "single");

        // Backpressure: results 0x0001, 0x0002, 0x0003, 0xFFFC under keys 0,1,1,2.
        do_reset();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'h0003;
        check("bp_ready_0", {31'd0, bus.in_ready}, 32'd1);
        step();
        bus.in_data = 16'h0007;
        check("bp_ready_1", {31'd0, bus.in_ready}, 32'd1);
        step();
        check("bp_ready_drop", {31'd0, bus.in_ready}, 32'd0);
        check("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
        check("bp_hold_data", {16'd0, bus.out_data}, 32'h0001);
        bus.in_data = 16'h0004;
        step();
        check("bp_still_blocked", {31'd0, bus.in_ready}, 32'd0);
        check("bp_hold_data_2", {16'd0, bus.out_data}, 32'h0001);
        check("bp_count_2", {16'd0, word_count}, 32'd2);
        bus.out_ready = 1'b1;
        #1;
        check("bp_ready_release", {31'd0, bus.in_ready}, 32'd1);
        step();
        check("bp_out_1", {16'd0, bus.out_data}, 32'h0002);
        bus.in_data = 16'h0006;
        step();
        check("bp_out_2", {16'd0, bus.out_data}, 32'h0003);
        bus.in_valid = 1'b0;
        step();
        check("bp_out_3", {16'd0, bus.out_data}, 32'hFFFC);
        step();
        check("bp_drained", {31'd0, bus.out_valid}, 32'd0);
        check("bp_count_4", {16'd0, word_count}, 32'd4);
        // Fifth key must be F4 = 3: 0x0003 ^ 3 = 0 -> 0x0000.
        send_word(16'h0003, 1'b0);
        collect(16'h0000, "bp_key_advance");

        // Keystream wrap: F24 = 0xB520 -> 0x6CE0, F25 = 0x2511 -> 0xE30F.
        do_reset();
        run_stream(26, -1);
        check("wrap_out_2", {16'd0, outs[2]}, 32'hFFFF);
        check("wrap_out_3", {16'd0, outs[3]}, 32'hFFFE);
        check("wrap_out_24", {16'd0, outs[24]}, 32'h6CE0);
        check("wrap_out_25", {16'd0, outs[25]}, 32'hE30F);
        check("wrap_word_count", {16'd0, word_count}, 32'd26);

        // Resync collision on word 5: keys 3, 5, then 0, 1.
        do_reset();
        run_stream(8, 5);
        check("rs_out_4", {16'd0, outs[4]}, 32'h0001);
        check("rs_out_5", {16'd0, outs[5]}, 32'h0003);
        check("rs_out_6", {16'd0, outs[6]}, 32'h0000);
        check("rs_out_7", {16'd0, outs[7]}, 32'hFFFF);
        check("rs_word_count", {16'd0, word_count}, 32'd8);

        // Reset with both stages full and the consumer stalled.
        do_reset();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'h0005;
        step();
        bus.in_data = 16'h0009;
        step();
        bus.in_valid = 1'b0;
        check("mr_full_valid", {31'd0, bus.out_valid}, 32'd1);
        check("mr_full_ready", {31'd0, bus.in_ready}, 32'd0);
        check("mr_full_count", {16'd0, word_count}, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_async_valid", {31'd0, bus.out_valid}, 32'd0);
        check("mr_async_count", {16'd0, word_count}, 32'd0);
        @(negedge clk);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        send_word(16'h0003, 1'b0);
        collect(16'h0001, "mr_first_key");
        check("mr_word_count", {16'd0, word_count}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
